piso_8b: RTL and testbench
==========================

PISO_8B -- requirements
Module: piso_8b

Interface
REQ-001 The module SHALL have parameter MSB_FIRST, default 0, meaning 0 = shift LSB first and 1 = shift MSB first.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d  input  8  parallel byte to serialise.
REQ-005 ld_valid  input  1  upstream asserts when d holds a byte to load.
REQ-006 ld_ready  output  1  block can accept d this cycle.
REQ-007 sout  output  1  current serial bit.
REQ-008 sout_valid  output  1  sout holds a valid bit.
REQ-009 sout_ready  input  1  downstream consumes sout this cycle.
REQ-010 sout_last  output  1  current bit is the 8th (final) bit of the byte.
REQ-011 busy  output  1  a byte is loaded and not fully shifted out.

Function
REQ-012 The block SHALL use two states, IDLE and SHIFT, with a 3-bit bit counter cnt and an 8-bit shift register sr.
REQ-013 Load handshake: a load SHALL occur on an edge where ld_valid=1 and ld_ready=1; sr<=d, cnt<=0, state<=SHIFT.
REQ-014 ld_ready SHALL be 1 in IDLE, and 1 in SHIFT only when cnt=7 and sout_ready=1 (final-bit consume); otherwise 0.
REQ-015 Output handshake: a bit SHALL be consumed on an edge where sout_valid=1 and sout_ready=1.
REQ-016 sout_valid SHALL equal (state==SHIFT); busy SHALL equal sout_valid.
REQ-017 sout SHALL be sr[0] when MSB_FIRST=0 and sr[7] when MSB_FIRST=1; sout SHALL be 0 in IDLE.
REQ-018 On a consume with cnt<7, sr SHALL shift one place toward the output end with 0 filled in, and cnt SHALL increment by 1.
REQ-019 sout_last SHALL equal (state==SHIFT and cnt==7).
REQ-020 On a consume with cnt=7 and no simultaneous load, state SHALL go to IDLE and sr SHALL clear to 0.
REQ-021 On a consume with cnt=7 and a simultaneous load, state SHALL stay SHIFT, sr<=d, and cnt<=0, giving back-to-back bytes with no gap.
REQ-022 With sout_ready=0 in SHIFT, sr, cnt, state and all outputs SHALL hold unchanged for any number of cycles.
REQ-023 Latency SHALL be as follows: the first bit of a loaded byte is valid on sout in the cycle after the load edge, and a byte takes 8 consume cycles.
REQ-024 ld_valid while ld_ready=0 SHALL be ignored, with no state change.
REQ-025 cnt SHALL never exceed 7 and SHALL not wrap except by reload to 0 per REQ-013/REQ-021.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE and sr=0, cnt=0, independent of clk.
REQ-027 Outputs during reset SHALL be ld_ready=1, sout=0, sout_valid=0, sout_last=0, busy=0.
REQ-028 Reset asserted mid-byte SHALL discard the partial byte; after release, the first ld_valid edge SHALL load normally.

Structure
REQ-029 The shared package SHALL hold the state encodings IDLE=1'b0 and SHIFT=1'b1, the data width constant 8, and the counter terminal value 7.
REQ-030 The block SHALL contain one sub-module, dff_1b (a 1-bit D flop with asynchronous active-low reset to 0), instantiated for every state bit: 1 state, 3 cnt, and 8 sr.
REQ-031 Next-state selection for each sr bit (load d / shift / hold) SHALL be built from the team's 1-bit gate cells, not behavioural assignment.

Verification
REQ-032 Reset, then load d=8'hA5 with MSB_FIRST=0 and sout_ready=1 -> sout=1,0,1,0,0,1,0,1 on cycles 1-8; sout_last=1 only on cycle 8; IDLE on cycle 9.
REQ-033 MSB_FIRST=1, load 8'h81 -> sout=1,0,0,0,0,0,0,1; ld_ready=0 during cycles 1-7.
REQ-034 Load 8'h0F, hold sout_ready=0 for 5 cycles after bit 3 -> sout/cnt frozen for those 5 cycles; remaining bits resume intact; 8 consumes total.
REQ-035 Load 8'h3C, present 8'hC3 with ld_valid=1 during bit 8 -> no idle gap; the 16 serial bits are 3C then C3 (LSB first); sout_valid continuous.
REQ-036 Drop rst_n asynchronously mid-cycle at bit 4 of 8'hFF -> sout_valid and busy go to 0 immediately; after release, load 8'h01 -> sout=1 then seven 0s.
REQ-037 Assert ld_valid with 8'h55 during bits 2-7 of a byte -> ignored; the original byte completes unaltered.

Source files
------------

// File: rtl/piso_8b_pkg.sv
// Shared definitions for the 8-bit parallel-in serial-out shifter.
// Covers state encodings, width constants and the debug view of the control state.
package piso_8b_pkg;

    localparam int DATA_W = 8;
    localparam logic [2:0] CNT_LAST = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [2:0] cnt;
    } dbg_t;

endpackage

// File: rtl/piso_8b_if.sv
// Load and serial-output handshake bundle for piso_8b.
// Valid/ready rule: a transfer happens on a rising edge where valid and ready are both 1.
// Once valid is raised, its payload stays stable until that transfer occurs.
interface piso_8b_if;
    import piso_8b_pkg::*;

    logic [DATA_W-1:0] d;
    logic              ld_valid;
    logic              ld_ready;
    logic              sout;
    logic              sout_valid;
    logic              sout_ready;
    logic              sout_last;
    logic              busy;

    modport master (
        output d, ld_valid, sout_ready,
        input  ld_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  d, ld_valid, sout_ready,
        output ld_ready, sout, sout_valid, sout_last, busy
    );

endinterface

// File: rtl/dff_1b.sv
// Single-bit D flop with asynchronous active-low clear.
// Every state bit of piso_8b is stored in one of these.
module dff_1b (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/piso_8b.sv
// 8-bit parallel-in serial-out shifter with valid/ready on both sides.
// A final-bit consume can overlap the next load, so successive bytes stream without gaps.
module piso_8b
    import piso_8b_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    piso_8b_if.slave   bus,
    output dbg_t       dbg
);

    logic              state_bit;
    logic              state_d;
    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_d;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] d_in;
    logic              in_shift;
    logic              last;
    logic              consume;
    logic              load;
    logic              shift_en;
    logic              clear;
    wire               hold;
    wire  [DATA_W-1:0] sr_d;

    assign state_q  = state_t'(state_bit);
    assign in_shift = (state_q == SHIFT);
    assign last     = in_shift && (cnt_q == CNT_LAST);
    assign consume  = in_shift && bus.sout_ready;
    assign d_in     = bus.d;

    assign bus.ld_ready   = !in_shift || (last && bus.sout_ready);
    assign bus.sout_valid = in_shift;
    assign bus.busy       = in_shift;
    assign bus.sout_last  = last;
    assign bus.sout       = in_shift && (MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0]);

    assign dbg = '{state: state_q, cnt: cnt_q};

    // load and shift_en are mutually exclusive: a load in SHIFT needs cnt at its last value.
    always_comb begin
        load     = bus.ld_valid && bus.ld_ready;
        shift_en = consume && !last;
        clear    = consume && last && !load;
        state_d  = state_bit;
        cnt_d    = cnt_q;
        if (load) begin
            state_d = SHIFT;
            cnt_d   = 3'd0;
        end else if (shift_en) begin
            cnt_d   = cnt_q + 3'd1;
        end else if (clear) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end
    end

    always_comb begin
        sh = MSB_FIRST ? {sr_q[DATA_W-2:0], 1'b0} : {1'b0, sr_q[DATA_W-1:1]};
    end

    nor u_hold (hold, load, shift_en, clear);

    dff_1b u_state_ff (.clk(clk), .rst_n(rst_n), .d(state_d), .q(state_bit));

    for (genvar c = 0; c < 3; c++) begin : g_cnt
        dff_1b u_ff (.clk(clk), .rst_n(rst_n), .d(cnt_d[c]), .q(cnt_q[c]));
    end

    // Per-bit mux: exactly one of load/shift/hold selects, none selected means clear to 0.
    for (genvar i = 0; i < DATA_W; i++) begin : g_sr
        wire t_ld;
        wire t_sh;
        wire t_hd;
        and u_ld (t_ld, load, d_in[i]);
        and u_sh (t_sh, shift_en, sh[i]);
        and u_hd (t_hd, hold, sr_q[i]);
        or  u_or (sr_d[i], t_ld, t_sh, t_hd);
        dff_1b u_ff (.clk(clk), .rst_n(rst_n), .d(sr_d[i]), .q(sr_q[i]));
    end

endmodule

// File: tb/tb_piso_8b.sv
// Directed self-checking bench for piso_8b, covering LSB-first and MSB-first instances.
module tb_piso_8b;
    import piso_8b_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    dbg_t dbg0;
    dbg_t dbg1;

    piso_8b_if b0 ();
    piso_8b_if b1 ();

    piso_8b #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .dbg(dbg0));
    piso_8b #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg(dbg1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        b0.d = 8'h00; b0.ld_valid = 1'b0; b0.sout_ready = 1'b1;
        b1.d = 8'h00; b1.ld_valid = 1'b0; b1.sout_ready = 1'b1;
        #3;
        checks++;
        if ({b0.ld_ready, b0.sout, b0.sout_valid, b0.sout_last, b0.busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outs got %b exp 10000",
                     {b0.ld_ready, b0.sout, b0.sout_valid, b0.sout_last, b0.busy});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dbg0 !== '{state: IDLE, cnt: 3'd0} || b1.sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got state=%b cnt=%0d v1=%b exp 0 0 0",
                     dbg0.state, dbg0.cnt, b1.sout_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        seq = 8'b1010_0101;
        @(negedge clk);
        b0.d = 8'hA5; b0.ld_valid = 1'b1; b0.sout_ready = 1'b1;
        @(negedge clk);
        b0.ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (b0.sout !== seq[7-k] || b0.sout_valid !== 1'b1 || b0.busy !== 1'b1) begin
                errors++;
                $display("FAIL lsb_bit k=%0d got sout=%b v=%b busy=%b exp %b 1 1",
                         k, b0.sout, b0.sout_valid, b0.busy, seq[7-k]);
            end
            checks++;
            if (b0.sout_last !== (k == 7)) begin
                errors++;
                $display("FAIL lsb_last k=%0d got %b exp %b", k, b0.sout_last, (k == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (b0.sout_valid !== 1'b0 || b0.ld_ready !== 1'b1 || b0.sout !== 1'b0) begin
            errors++;
            $display("FAIL lsb_idle got v=%b rdy=%b sout=%b exp 0 1 0",
                     b0.sout_valid, b0.ld_ready, b0.sout);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        seq = 8'b1000_0001;
        @(negedge clk);
        b1.d = 8'h81; b1.ld_valid = 1'b1; b1.sout_ready = 1'b1;
        @(negedge clk);
        b1.ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (b1.sout !== seq[7-k]) begin
                errors++;
                $display("FAIL msb_bit k=%0d got %b exp %b", k, b1.sout, seq[7-k]);
            end
            checks++;
            if (b1.ld_ready !== (k == 7)) begin
                errors++;
                $display("FAIL msb_ld_ready k=%0d got %b exp %b", k, b1.ld_ready, (k == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (b1.sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_idle got %b exp 0", b1.sout_valid);
        end
    endtask

    task automatic test_stall();
        logic [7:0] seq;
        int k;
        int stalls;
        int consumed;
        seq = 8'b1111_0000;
        k = 0; stalls = 0; consumed = 0;
        @(negedge clk);
        b0.d = 8'h0F; b0.ld_valid = 1'b1; b0.sout_ready = 1'b1;
        @(negedge clk);
        b0.ld_valid = 1'b0;
        while (k < 8) begin
            checks++;
            if (b0.sout !== seq[7-k] || dbg0.cnt !== 3'(k) || b0.sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_bit k=%0d stalls=%0d got sout=%b cnt=%0d v=%b exp %b %0d 1",
                         k, stalls, b0.sout, dbg0.cnt, b0.sout_valid, seq[7-k], k);
            end
            if (k == 3 && stalls < 5) begin
                b0.sout_ready = 1'b0;
                stalls++;
            end else begin
                b0.sout_ready = 1'b1;
                consumed++;
                k++;
            end
            @(negedge clk);
        end
        checks++;
        if (b0.sout_valid !== 1'b0 || consumed != 8) begin
            errors++;
            $display("FAIL stall_end got v=%b consumed=%0d exp 0 8", b0.sout_valid, consumed);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq;
        seq = 16'b0011_1100_1100_0011;
        @(negedge clk);
        b0.d = 8'h3C; b0.ld_valid = 1'b1; b0.sout_ready = 1'b1;
        @(negedge clk);
        b0.ld_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 8) b0.ld_valid = 1'b0;
            checks++;
            if (b0.sout !== seq[15-k] || b0.sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_bit k=%0d got sout=%b v=%b exp %b 1",
                         k, b0.sout, b0.sout_valid, seq[15-k]);
            end
            checks++;
            if (b0.sout_last !== (k == 7 || k == 15)) begin
                errors++;
                $display("FAIL b2b_last k=%0d got %b exp %b", k, b0.sout_last, (k == 7 || k == 15));
            end
            if (k == 7) begin
                b0.d = 8'hC3; b0.ld_valid = 1'b1;
                checks++;
                if (b0.ld_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ld_ready got %b exp 1", b0.ld_ready);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (b0.sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got %b exp 0", b0.sout_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        b0.d = 8'hFF; b0.ld_valid = 1'b1; b0.sout_ready = 1'b1;
        @(negedge clk);
        b0.ld_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (b0.sout !== 1'b1 || dbg0.cnt !== 3'd3) begin
            errors++;
            $display("FAIL arst_pre got sout=%b cnt=%0d exp 1 3", b0.sout, dbg0.cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b0.ld_ready, b0.sout, b0.sout_valid, b0.sout_last, b0.busy} !== 5'b10000
            || dbg0.cnt !== 3'd0) begin
            errors++;
            $display("FAIL arst_now got %b cnt=%0d exp 10000 0",
                     {b0.ld_ready, b0.sout, b0.sout_valid, b0.sout_last, b0.busy}, dbg0.cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b0.d = 8'h01; b0.ld_valid = 1'b1;
        @(negedge clk);
        b0.ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (b0.sout !== (k == 0) || b0.sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL arst_reload k=%0d got sout=%b v=%b exp %b 1",
                         k, b0.sout, b0.sout_valid, (k == 0));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_load();
        logic [7:0] seq;
        seq = 8'b0110_0011;
        @(negedge clk);
        b0.d = 8'hC6; b0.ld_valid = 1'b1; b0.sout_ready = 1'b1;
        @(negedge clk);
        b0.ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 1 && k <= 6) begin
                b0.d = 8'h55; b0.ld_valid = 1'b1;
                checks++;
                if (b0.ld_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ign_ld_ready k=%0d got %b exp 0", k, b0.ld_ready);
                end
            end else begin
                b0.ld_valid = 1'b0;
            end
            checks++;
            if (b0.sout !== seq[7-k] || dbg0.cnt !== 3'(k)) begin
                errors++;
                $display("FAIL ign_bit k=%0d got sout=%b cnt=%0d exp %b %0d",
                         k, b0.sout, dbg0.cnt, seq[7-k], k);
            end
        end
        @(negedge clk);
        checks++;
        if (b0.sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle got %b exp 0", b0.sout_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_ignored_load();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
